// File: rtl/ms_countdown_timer.sv
// Millisecond countdown timer fed by a 1 ms tick stream. It supports one-shot or
// periodic reload, pause and abort, and it enables the tick generator only while counting.
//   state | meaning
//   IDLE  | no countdown active
//   RUN   | counting ms_tick pulses
//   HOLD  | paused, remaining frozen
module ms_countdown_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  input  logic             ms_tick,
  output logic             tick_enable,
  output logic             busy,
  output logic [WIDTH-1:0] remaining,
  output logic             time_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] remaining_next;
  logic             time_out_next;
  logic [WIDTH-1:0] reload_val, reload_val_next;
  logic             reload_flag, reload_flag_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      time_out    <= 1'b0;
      reload_val  <= '0;
      reload_flag <= 1'b0;
    end else begin
      state       <= state_next;
      remaining   <= remaining_next;
      time_out    <= time_out_next;
      reload_val  <= reload_val_next;
      reload_flag <= reload_flag_next;
    end
  end

  always_comb begin
    state_next       = state;
    remaining_next   = remaining;
    time_out_next    = 1'b0;
    reload_val_next  = reload_val;
    reload_flag_next = reload_flag;

    if (abort) begin
      state_next     = IDLE;
      remaining_next = '0;
    end else if (start) begin
      if (duration != '0) begin
        state_next       = RUN;
        remaining_next   = duration;
        reload_val_next  = duration;
        reload_flag_next = auto_reload;
      end else begin
        state_next     = IDLE;
        remaining_next = '0;
        time_out_next  = 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          // Pause only takes effect next cycle, so a tick in this cycle still counts.
          if (pause) state_next = HOLD;
          if (ms_tick) begin
            if (remaining == WIDTH'(1)) begin
              time_out_next = 1'b1;
              if (reload_flag) begin
                remaining_next = reload_val;
              end else begin
                remaining_next = '0;
                state_next     = IDLE;
              end
            end else if (remaining > WIDTH'(1)) begin
              remaining_next = remaining - WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (!pause) state_next = RUN;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign tick_enable = (state == RUN);

endmodule

// File: tb/tb_ms_countdown_timer.sv
// Directed self-checking bench for ms_countdown_timer. Its expected values are hand-computed.
module tb_ms_countdown_timer;

  localparam int WIDTH = 10;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] duration = '0;
  logic             auto_reload = 1'b0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic             ms_tick = 1'b0;
  logic             tick_enable;
  logic             busy;
  logic [WIDTH-1:0] remaining;
  logic             time_out;

  int n_cmp = 0;
  int n_err = 0;

  ms_countdown_timer #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .duration    (duration),
    .auto_reload (auto_reload),
    .pause       (pause),
    .abort       (abort),
    .ms_tick     (ms_tick),
    .tick_enable (tick_enable),
    .busy        (busy),
    .remaining   (remaining),
    .time_out    (time_out)
  );

  always #10 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic tick();
    ms_tick = 1'b1;
    cyc();
    ms_tick = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int rem, input bit to, input bit bsy, input bit te);
    check({tag, ".remaining"}, 32'(remaining), 32'(rem));
    check({tag, ".time_out"}, 32'(time_out), 32'(to));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".tick_enable"}, 32'(tick_enable), 32'(te));
  endtask

  initial begin
    idle(2);
    reset = 1'b0;
    cyc();
    check_all("reset", 0, 0, 0, 0);

    // One-shot, duration 3, tick every 4 clocks.
    start = 1'b1; duration = 3; auto_reload = 1'b0;
    cyc();
    start = 1'b0;
    check_all("os_load", 3, 0, 1, 1);
    idle(3); tick(); check_all("os_t1", 2, 0, 1, 1);
    idle(3); tick(); check_all("os_t2", 1, 0, 1, 1);
    idle(3); tick(); check_all("os_t3", 0, 1, 0, 0);
    cyc(); check_all("os_after", 0, 0, 0, 0);
    idle(2); tick(); check_all("os_idle_tick", 0, 0, 0, 0);

    // Periodic, duration 2, 8 ticks.
    start = 1'b1; duration = 2; auto_reload = 1'b1;
    cyc();
    start = 1'b0; auto_reload = 1'b0;
    check_all("per_load", 2, 0, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      idle(3); tick();
      if (k % 2 == 0) check_all($sformatf("per_t%0d", k), 2, 1, 1, 1);
      else            check_all($sformatf("per_t%0d", k), 1, 0, 1, 1);
    end
    cyc(); check("per_pulse_width", 32'(time_out), 32'd0);

    // Abort with remaining 2: idle, cleared, no time_out.
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check_all("abort_rem2", 0, 0, 0, 0);

    // Pause: duration 5, 2 ticks, hold 20 clocks with 5 injected ticks.
    start = 1'b1; duration = 5;
    cyc();
    start = 1'b0;
    idle(3); tick();
    idle(3); tick(); check_all("pz_pre", 3, 0, 1, 1);
    pause = 1'b1;
    cyc(); check_all("pz_enter", 3, 0, 1, 0);
    for (int i = 0; i < 19; i++) begin
      ms_tick = (i % 4 == 1);
      cyc();
      check("pz_hold.remaining", 32'(remaining), 32'd3);
      check("pz_hold.tick_enable", 32'(tick_enable), 32'd0);
    end
    ms_tick = 1'b0; pause = 1'b0;
    cyc(); check_all("pz_release", 3, 0, 1, 1);
    idle(3); tick(); check_all("pz_t3", 2, 0, 1, 1);
    idle(3); tick(); check_all("pz_t4", 1, 0, 1, 1);
    idle(3); tick(); check_all("pz_t5", 0, 1, 0, 0);

    // A tick that coincides with the pause request is still counted.
    start = 1'b1; duration = 4;
    cyc();
    start = 1'b0;
    pause = 1'b1; ms_tick = 1'b1;
    cyc();
    ms_tick = 1'b0;
    check_all("pz_same_tick", 3, 0, 1, 0);
    pause = 1'b0;
    abort = 1'b1; cyc(); abort = 1'b0;

    // Start with zero duration.
    start = 1'b1; duration = 0;
    cyc();
    start = 1'b0;
    check_all("zero_dur", 0, 1, 0, 0);
    cyc(); check_all("zero_dur_after", 0, 0, 0, 0);

    // Start coincident with the final tick: restart, no time_out.
    start = 1'b1; duration = 2;
    cyc();
    start = 1'b0;
    idle(1); tick(); check_all("coin_pre", 1, 0, 1, 1);
    start = 1'b1; duration = 4; ms_tick = 1'b1;
    cyc();
    start = 1'b0; ms_tick = 1'b0;
    check_all("coin_restart", 4, 0, 1, 1);
    cyc(); check("coin_no_pulse", 32'(time_out), 32'd0);

    // Abort and start together: abort wins.
    abort = 1'b1; start = 1'b1; duration = 7;
    cyc();
    abort = 1'b0; start = 1'b0;
    check_all("abort_start", 0, 0, 0, 0);

    // Reset mid-countdown.
    start = 1'b1; duration = 9;
    cyc();
    start = 1'b0;
    tick(); check_all("rst_pre", 8, 0, 1, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_all("rst_run", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ms_countdown_timer.md
# ms_countdown_timer

Consumer of the 1 ms tick pulse stream: loads a duration in milliseconds, counts down one unit per `ms_tick` pulse, and emits a one-cycle `time_out` pulse at expiry. It drives `tick_enable` back to the 1 ms tick generator, so the generator runs only while a countdown is active. It provides the game's variable delays: asteroid spawn interval, fall-step period and invulnerability window, with optional periodic reload.

## Interface

Parameters:
- `WIDTH`, 10: width of duration and remaining count; maximum duration is 2^WIDTH-1 ms.

Ports:
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  single-cycle request; loads `duration` and begins counting.
- `duration`  in  WIDTH  countdown length in ms; sampled only on the `start` cycle.
- `auto_reload`  in  1  sampled with `start`. 1 = periodic mode, reloads the latched duration at each expiry.
- `pause`  in  1  level; freezes the count while high.
- `abort`  in  1  single-cycle; cancels the countdown with no `time_out`.
- `ms_tick`  in  1  one-cycle pulse from the 1 ms tick generator.
- `tick_enable`  out  1  enable to the tick generator; high only in RUN.
- `busy`  out  1  high in RUN or HOLD.
- `remaining`  out  WIDTH  ms left in the current period.
- `time_out`  out  1  one-cycle expiry pulse.

## Operation

- States:
  - IDLE: reset state.
  - RUN: counting.
  - HOLD: paused.
- Outputs:
  - `busy` = (state != IDLE).
  - `tick_enable` = (state == RUN).
  - `remaining` and `time_out` are registers.
  - No combinational path from any input to any output.
- Per-cycle priority: `reset` > `abort` > `start` > `ms_tick`/`pause`.
- `abort` in any state:
  - next state IDLE, `remaining` <= 0, `time_out` <= 0.
  - `start` in the same cycle is ignored.
- `start` with `duration` != 0 in any state:
  - `remaining` <= `duration`.
  - Reload register <= `duration`; reload flag <= `auto_reload`.
  - Next state RUN. A `ms_tick` in the same cycle is ignored.
  - A `start` in RUN or HOLD restarts the countdown and never produces `time_out` for the aborted period.
- `start` with `duration` == 0:
  - `time_out` <= 1 for one cycle.
  - Next state IDLE, `remaining` <= 0.
- RUN, `ms_tick` high:
  - If `remaining` > 1: `remaining` <= `remaining` - 1.
  - If `remaining` == 1: `time_out` <= 1.
    - Reload flag set: `remaining` <= reload value, stay in RUN.
    - Reload flag clear: `remaining` <= 0, next state IDLE.
- RUN, `pause` high: next state HOLD. A `ms_tick` in that same cycle is still counted, since pause takes effect the following cycle.
- HOLD:
  - `ms_tick` is ignored and `remaining` holds.
  - `pause` low: next state RUN.
- IDLE: `ms_tick` and `pause` are ignored.
- `time_out` is 0 in every cycle not explicitly set above.
- Width rules: `remaining` never underflows; a decrement only occurs when `remaining` >= 2.

## Timing

- Reset values: state IDLE, `remaining` 0, `time_out` 0, `busy` 0, `tick_enable` 0. Reload register and reload flag are 0.
- Reset asserted mid-countdown: outputs are at reset values the next cycle, with no `time_out`.
- `start` at cycle t: `busy`, `tick_enable` and `remaining` = `duration` are visible at t+1.
- Final `ms_tick` at cycle t: `time_out` high at t+1 only.
  - One-shot mode: `busy`/`tick_enable` low at t+1.
  - Periodic mode: `remaining` equals the reload value at t+1.
- `pause` rising at t: HOLD from t+1, and `tick_enable` low from t+1. `pause` falling at t: RUN from t+1.
- Tick phase: the tick generator does not clear its prescaler when its enable drops. The first tick after entering RUN may arrive early, so the timing tolerance is -1 ms / +0 ms on the first period only.
- Periodic mode gives exactly `duration` ticks between consecutive `time_out` pulses, with no lost tick at reload.

## Test plan

- Reset, then `start` with `duration`=3 and `auto_reload`=0, one `ms_tick` every 4 clocks:
  - `remaining` goes 3, 2, 1.
  - `time_out` pulses one cycle after the 3rd tick.
  - `busy` falls in the same cycle as `time_out`.
  - No further pulses.
- `start` with `duration`=2 and `auto_reload`=1, 8 ticks: `time_out` after ticks 2, 4, 6 and 8; `remaining` goes 2, 1, 2, 1...; `busy` stays high.
- `duration`=5; after 2 ticks assert `pause` for 20 clocks with 5 ticks injected:
  - `remaining` holds at 3 and `tick_enable` is 0 during the hold.
  - After release, 3 more ticks give `time_out`.
- Edge cases:
  - `start` with `duration`=0: `time_out` at t+1, `busy` stays 0.
  - `start` coincident with `ms_tick` in RUN (`remaining`=1, new `duration`=4): no `time_out`, `remaining`=4.
- Cancellation:
  - `abort` with `remaining`=2: IDLE and `remaining`=0 next cycle, with no `time_out`.
  - `abort` and `start` in the same cycle: IDLE.
  - `reset` in RUN: all outputs return to 0.
